// File: rtl/entrada_chaves.sv
// rtl/entrada_chaves.sv - switch input block: button debounce and value capture handshake with the processor
// Optional macro ENTRADA_CHAVES_SINAL_EN: sign-extend the captured switch value instead of zero-extending it.
module entrada_chaves #(
  parameter int LARGURA_CHAVES  = 10,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic                      botao,
  input  logic                      req,
  output logic [31:0]               numero,
  output logic                      pronto,
  output logic                      espera
);

  localparam int            CW   = 21;
  localparam logic [CW-1:0] ALVO = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    AGUARDA_PRESS,
    AGUARDA_SOLTA,
    ENTREGA
  } estado_t;

  estado_t         estado, proximo;
  logic            sinc1, sinc2;
  logic            bt_db;
  logic [CW-1:0]   cont;
  logic            difere, vira, queda, subida, captura;
  logic [31:0]     estendido;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1 <= 1'b1;
      sinc2 <= 1'b1;
    end else begin
      sinc1 <= botao;
      sinc2 <= sinc1;
    end
  end

  // vira fires on the clock that completes DEBOUNCE_CICLOS differing samples,
  // so the FSM reacts on the same edge that bt_db flips.
  assign difere = (sinc2 != bt_db);
  assign vira   = difere && (cont >= ALVO);
  assign queda  = vira && bt_db;
  assign subida = vira && !bt_db;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bt_db <= 1'b1;
      cont  <= '0;
    end else if (!difere) begin
      cont  <= '0;
    end else if (vira) begin
      bt_db <= sinc2;
      cont  <= '0;
    end else begin
      cont  <= cont + 1'b1;
    end
  end

`ifdef ENTRADA_CHAVES_SINAL_EN
  assign estendido = {{(32-LARGURA_CHAVES){chaves[LARGURA_CHAVES-1]}}, chaves};
`else
  assign estendido = {{(32-LARGURA_CHAVES){1'b0}}, chaves};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // req low aborts the wait and wins over a press or release on the same clock.
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:        if (req) proximo = AGUARDA_PRESS;
      AGUARDA_PRESS: if (!req) proximo = OCIOSO;
                     else if (queda) proximo = AGUARDA_SOLTA;
      AGUARDA_SOLTA: if (!req) proximo = OCIOSO;
                     else if (subida) proximo = ENTREGA;
      ENTREGA:       proximo = OCIOSO;
      default:       proximo = OCIOSO;
    endcase
  end

  assign captura = (estado == AGUARDA_PRESS) && req && queda;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      numero <= '0;
    end else if (captura) begin
      numero <= estendido;
    end
  end

  always_comb begin
    espera = 1'b0;
    pronto = 1'b0;
    case (estado)
      AGUARDA_PRESS: espera = 1'b1;
      AGUARDA_SOLTA: espera = 1'b1;
      ENTREGA:       pronto = 1'b1;
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_entrada_chaves.sv
// tb/tb_entrada_chaves.sv - directed bench for entrada_chaves with DEBOUNCE_CICLOS=4, LARGURA_CHAVES=10
module tb_entrada_chaves;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  chaves;
  logic        botao;
  logic        req;
  logic [31:0] numero;
  logic        pronto;
  logic        espera;

  int n_checks = 0;
  int n_fail   = 0;
  int p;
  int lat;

  entrada_chaves #(
    .LARGURA_CHAVES (10),
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .chaves(chaves),
    .botao (botao),
    .req   (req),
    .numero(numero),
    .pronto(pronto),
    .espera(espera)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: obtido %0h esperado %0h", tag, obs, exp);
    end
  endtask

  // Waits a bounded time, counting pronto pulses; drops req as the processor would.
  task automatic espera_pronto(output int pulsos);
    pulsos = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (pronto) begin
        pulsos++;
        req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  task automatic transacao(input logic [9:0] v, output int pulsos);
    chaves = v;
    req    = 1'b1;
    @(negedge clock);
    botao = 1'b0;
    repeat (10) @(negedge clock);
    botao = 1'b1;
    espera_pronto(pulsos);
  endtask

  initial begin
    reset  = 1'b1;
    botao  = 1'b1;
    req    = 1'b0;
    chaves = '0;
    repeat (2) @(negedge clock);
    check("reset_numero", numero, 32'd0);
    check("reset_pronto", {31'd0, pronto}, 32'd0);
    check("reset_espera", {31'd0, espera}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("ocioso_espera", {31'd0, espera}, 32'd0);

    // normal transaction, latency and post-capture switch change
    chaves = 10'd123;
    req    = 1'b1;
    @(negedge clock);
    check("t1_espera_req", {31'd0, espera}, 32'd1);
    botao = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (lat == 0 && numero == 32'd123) lat = i;
    end
    check("t1_latencia", {31'd0, (lat >= 6 && lat <= 7)}, 32'd1);
    check("t1_espera_solta", {31'd0, espera}, 32'd1);
    chaves = 10'd456;
    botao  = 1'b1;
    espera_pronto(p);
    check("t1_pulsos", p, 32'd1);
    check("t1_espera_fim", {31'd0, espera}, 32'd0);
    check("t1_numero", numero, 32'd123);

    // bounce never reaches 4 stable samples
    req = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      botao = ((i % 4) < 2) ? 1'b0 : 1'b1;
      @(negedge clock);
    end
    botao = 1'b1;
    p = 0;
    repeat (10) begin
      @(negedge clock);
      if (pronto) p++;
    end
    check("bounce_espera", {31'd0, espera}, 32'd1);
    check("bounce_numero", numero, 32'd123);
    check("bounce_pulsos", p, 32'd0);

    // abort before any press
    req = 1'b0;
    p   = 0;
    repeat (5) begin
      @(negedge clock);
      if (pronto) p++;
    end
    check("abort_espera", {31'd0, espera}, 32'd0);
    check("abort_numero", numero, 32'd123);
    check("abort_pulsos", p, 32'd0);

    // sign handling of the top switch bit
    transacao(10'h3FF, p);
    check("sinal_pulsos", p, 32'd1);
`ifdef ENTRADA_CHAVES_SINAL_EN
    check("sinal_numero", numero, 32'hFFFFFFFF);
`else
    check("sinal_numero", numero, 32'h000003FF);
`endif

    // reset asserted while waiting for release
    chaves = 10'd55;
    req    = 1'b1;
    @(negedge clock);
    botao = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_pre_espera", {31'd0, espera}, 32'd1);
    check("rst_pre_numero", numero, 32'd55);
    reset = 1'b1;
    #1;
    check("rst_async_numero", numero, 32'd0);
    check("rst_async_espera", {31'd0, espera}, 32'd0);
    check("rst_async_pronto", {31'd0, pronto}, 32'd0);
    @(negedge clock);
    botao = 1'b1;
    req   = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pos_espera", {31'd0, espera}, 32'd0);
    transacao(10'd7, p);
    check("rst_nova_pulsos", p, 32'd1);
    check("rst_nova_numero", numero, 32'd7);

    // button already held when req rises
    botao = 1'b0;
    repeat (10) @(negedge clock);
    chaves = 10'd9;
    req    = 1'b1;
    repeat (10) @(negedge clock);
    check("preso_espera", {31'd0, espera}, 32'd1);
    check("preso_numero", numero, 32'd7);
    botao = 1'b1;
    repeat (10) @(negedge clock);
    check("preso_solto_numero", numero, 32'd7);
    check("preso_solto_espera", {31'd0, espera}, 32'd1);
    chaves = 10'd12;
    botao  = 1'b0;
    repeat (10) @(negedge clock);
    check("preso_nova_numero", numero, 32'd12);
    botao = 1'b1;
    espera_pronto(p);
    check("preso_pulsos", p, 32'd1);
    check("preso_espera_fim", {31'd0, espera}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
